read_ptr: RTL and testbench

//  Read-side pointer and empty logic of the dual-clock FIFO; mirror of the write pointer block.

---
 rtl/read_ptr.sv | 116 +++++++++++
 tb/tb_read_ptr.sv | 124 ++++++++++++
 2 files changed

// File: rtl/read_ptr.sv
// ---------------------------------------------------------------------------
// read_ptr
//   Read-side pointer and empty logic of a dual-clock FIFO (mirror of the
//   write pointer block). Holds the binary read counter in the read clock
//   domain, exports a registered Gray read pointer to the write domain and
//   compares against the already-synchronised Gray write pointer to produce
//   the registered empty flag.
//
//   Optional feature macro: FIFO_RD_LEVEL_EN
//     defined   -> registered fill level and almost-empty flag are built
//     undefined -> level_o tied to 0, almost_empty_o follows fifo_empty_o
//
// Ports
//   clk_i           read-domain clock
//   rst_i           asynchronous reset, active-low
//   wr_ptr_2_i      Gray write pointer, synchronised into read domain
//   inc_i           read request
//   ptr_o           Gray read pointer (to write-domain synchroniser)
//   addr_o          RAM read address (low bits of binary read counter)
//   fifo_empty_o    FIFO empty, registered
//   rd_valid_o      RAM data at previously presented addr_o is valid
//   underflow_o     one-cycle pulse: read requested while empty
//   level_o         entries available (FIFO_RD_LEVEL_EN only)
//   almost_empty_o  level_o <= AE_THRESH (FIFO_RD_LEVEL_EN only)
// ---------------------------------------------------------------------------
module read_ptr #(
    parameter int unsigned ADDR_SIZE = 2,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_SIZE:0]   wr_ptr_2_i,
    input  logic                 inc_i,
    output logic [ADDR_SIZE:0]   ptr_o,
    output logic [ADDR_SIZE-1:0] addr_o,
    output logic                 fifo_empty_o,
    output logic                 rd_valid_o,
    output logic                 underflow_o,
    output logic [ADDR_SIZE:0]   level_o,
    output logic                 almost_empty_o
);

    logic [ADDR_SIZE:0] r_rd_bin;
    logic [ADDR_SIZE:0] r_ptr;
    logic               r_empty;
    logic               r_rd_valid;
    logic               r_underflow;

    logic               w_rd_en;
    logic [ADDR_SIZE:0] w_rd_bin_next;
    logic [ADDR_SIZE:0] w_gray_next;

    assign w_rd_en       = inc_i & ~r_empty;
    assign w_rd_bin_next = r_rd_bin + {{ADDR_SIZE{1'b0}}, w_rd_en};
    assign w_gray_next   = w_rd_bin_next ^ (w_rd_bin_next >> 1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_bin    <= '0;
            r_ptr       <= '0;
            r_empty     <= 1'b1;
            r_rd_valid  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_bin    <= w_rd_bin_next;
            r_ptr       <= w_gray_next;
            // Compared against the look-ahead pointer so empty asserts on the
            // same edge that consumes the last entry.
            r_empty     <= (w_gray_next == wr_ptr_2_i);
            r_rd_valid  <= w_rd_en;
            r_underflow <= inc_i & r_empty;
        end
    end

    assign ptr_o        = r_ptr;
    assign addr_o       = r_rd_bin[ADDR_SIZE-1:0];
    assign fifo_empty_o = r_empty;
    assign rd_valid_o   = r_rd_valid;
    assign underflow_o  = r_underflow;

`ifdef FIFO_RD_LEVEL_EN
    localparam logic [ADDR_SIZE:0] AE_T = AE_THRESH[ADDR_SIZE:0];

    logic [ADDR_SIZE:0] w_wr_bin;
    logic [ADDR_SIZE:0] w_level_next;
    logic [ADDR_SIZE:0] r_level;
    logic               r_almost_empty;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_wr_bin = '0;
        for (int unsigned i = 0; i <= ADDR_SIZE; i++) begin
            w_wr_bin[i] = ^(wr_ptr_2_i >> i);
        end
    end

    assign w_level_next = w_wr_bin - w_rd_bin_next;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_level        <= '0;
            r_almost_empty <= 1'b1;
        end else begin
            r_level        <= w_level_next;
            r_almost_empty <= (w_level_next <= AE_T);
        end
    end

    assign level_o        = r_level;
    assign almost_empty_o = r_almost_empty;
`else
    assign level_o        = '0;
    assign almost_empty_o = r_empty;
`endif

endmodule

// File: tb/tb_read_ptr.sv
module tb_read_ptr;

    localparam int unsigned AS = 2;

    logic          clk_i;
    logic          rst_i;
    logic [AS:0]   wr_ptr_2_i;
    logic          inc_i;
    logic [AS:0]   ptr_o;
    logic [AS-1:0] addr_o;
    logic          fifo_empty_o;
    logic          rd_valid_o;
    logic          underflow_o;
    logic [AS:0]   level_o;
    logic          almost_empty_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    read_ptr #(.ADDR_SIZE(AS), .AE_THRESH(1)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .wr_ptr_2_i     (wr_ptr_2_i),
        .inc_i          (inc_i),
        .ptr_o          (ptr_o),
        .addr_o         (addr_o),
        .fifo_empty_o   (fifo_empty_o),
        .rd_valid_o     (rd_valid_o),
        .underflow_o    (underflow_o),
        .level_o        (level_o),
        .almost_empty_o (almost_empty_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks every output; level/almost-empty expectations depend on build.
    task automatic chk_all(input string tag, input logic [AS:0] e_ptr, input logic [AS-1:0] e_addr,
                           input logic e_empty, input logic e_valid, input logic e_uf,
                           input logic [AS:0] e_level, input logic e_ae);
        check({tag, ".ptr"},   32'(ptr_o),        32'(e_ptr));
        check({tag, ".addr"},  32'(addr_o),       32'(e_addr));
        check({tag, ".empty"}, 32'(fifo_empty_o), 32'(e_empty));
        check({tag, ".valid"}, 32'(rd_valid_o),   32'(e_valid));
        check({tag, ".uf"},    32'(underflow_o),  32'(e_uf));
`ifdef FIFO_RD_LEVEL_EN
        check({tag, ".level"}, 32'(level_o),        32'(e_level));
        check({tag, ".ae"},    32'(almost_empty_o), 32'(e_ae));
`else
        check({tag, ".level"}, 32'(level_o),        32'(0));
        check({tag, ".ae"},    32'(almost_empty_o), 32'(e_empty));
        if (e_level == e_level && e_ae == e_ae) begin end
`endif
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // 1: reset, then requests against an empty FIFO
        rst_i      = 1'b0;
        wr_ptr_2_i = 3'b000;
        inc_i      = 1'b1;
        #22;
        chk_all("rst", 3'b000, 2'b00, 1, 0, 0, 3'd0, 1);
        rst_i = 1'b1;
        tick(); chk_all("uf1", 3'b000, 2'b00, 1, 0, 1, 3'd0, 1);
        tick(); chk_all("uf2", 3'b000, 2'b00, 1, 0, 1, 3'd0, 1);

        // 2: two entries written, drained back-to-back
        inc_i = 1'b0; wr_ptr_2_i = 3'b011;
        tick(); chk_all("s2.fill", 3'b000, 2'b00, 0, 0, 0, 3'd2, 0);
        inc_i = 1'b1;
        tick(); chk_all("s2.rd1", 3'b001, 2'b01, 0, 1, 0, 3'd1, 1);
        tick(); chk_all("s2.rd2", 3'b011, 2'b10, 1, 1, 0, 3'd0, 1);
        inc_i = 1'b0;

        // 3: write pointer to bin 5, drain three entries, then underflow
        wr_ptr_2_i = 3'b111;
        tick(); chk_all("s3.fill", 3'b011, 2'b10, 0, 0, 0, 3'd3, 0);
        inc_i = 1'b1;
        tick(); chk_all("s3.rd1", 3'b010, 2'b11, 0, 1, 0, 3'd2, 0);
        tick(); chk_all("s3.rd2", 3'b110, 2'b00, 0, 1, 0, 3'd1, 1);
        tick(); chk_all("s3.rd3", 3'b111, 2'b01, 1, 1, 0, 3'd0, 1);
        tick(); chk_all("s3.uf",  3'b111, 2'b01, 1, 0, 1, 3'd0, 1);
        inc_i = 1'b0;
        tick(); chk_all("s3.ufclr", 3'b111, 2'b01, 1, 0, 0, 3'd0, 1);

        // 4: pointer wrap through bin 7 -> 0
        wr_ptr_2_i = 3'b100;
        tick(); chk_all("s4.fill", 3'b111, 2'b01, 0, 0, 0, 3'd2, 0);
        inc_i = 1'b1; wr_ptr_2_i = 3'b000;
        tick(); chk_all("s4.rd1", 3'b101, 2'b10, 0, 1, 0, 3'd2, 0);
        tick(); chk_all("s4.rd2", 3'b100, 2'b11, 0, 1, 0, 3'd1, 1);
        tick(); chk_all("s4.rd3", 3'b000, 2'b00, 1, 1, 0, 3'd0, 1);
        inc_i = 1'b0;

        // 5: asynchronous reset mid-read
        wr_ptr_2_i = 3'b010;  // bin 3
        tick(); chk_all("s5.fill", 3'b000, 2'b00, 0, 0, 0, 3'd3, 0);
        inc_i = 1'b1;
        tick(); chk_all("s5.rd1", 3'b001, 2'b01, 0, 1, 0, 3'd2, 0);
        #2 rst_i = 1'b0;
        #1 chk_all("s5.arst", 3'b000, 2'b00, 1, 0, 0, 3'd0, 1);
        inc_i = 1'b0;
        tick(); chk_all("s5.hold", 3'b000, 2'b00, 1, 0, 0, 3'd0, 1);
        rst_i = 1'b1;
        tick(); chk_all("s5.rel", 3'b000, 2'b00, 0, 0, 0, 3'd3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
